alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//   MIPS32 integer ALU for the EX stage of the 5-stage pipeline. Decodes the raw 32-bit
//   instruction, selects operands from two register values, computes the result and a
//   3-bit status flag vector. Outputs are registered: one clock of latency.
// PARAMETERS
//   none (data width fixed at 32, flag width fixed at 3)
// PORTS
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   instruction  in   32  raw MIPS32 instruction word
//   regA         in   32  operand value for register field 0
//   regB         in   32  operand value for register field 1
//   result       out  32  registered ALU result
//   flags        out  3   registered {zero[2], negative[1], overflow[0]}
// BEHAVIOUR
// - Reset: result=0 and flags=3'b000 immediately while rst_n=0, independent of clk.
// - Each rising clk (rst_n=1): result/flags <= combinational function of current inputs.
// - Operand select: rs = (instr[25:21]==0) ? regA : regB; rt = (instr[20:16]==0) ? regA : regB.
// - Immediates: simm = sign-extend(instr[15:0]); zimm = zero-extend(instr[15:0]).
// - R-type (opcode 0), by funct instr[5:0]:
//   20 add: rs+rt, ovf     21 addu: rs+rt       22 sub: rs-rt, ovf   23 subu: rs-rt
//   24 and  25 or  26 xor  27 nor (~(rs|rt))    2a slt: signed rs<rt  2b sltu: unsigned rs<rt
//   00 sll / 02 srl / 03 sra: rt shifted by shamt instr[10:6] (sra arithmetic)
//   04 sllv / 06 srlv / 07 srav: rt shifted by rs[4:0]
// - I-type, by opcode instr[31:26]:
//   08 addi: rs+simm, ovf   09 addiu: rs+simm   0a slti: signed rs<simm   0b sltiu: unsigned rs<simm
//   0c andi / 0d ori / 0e xori: rs op zimm      04 beq / 05 bne: rs-rt
//   23 lw / 2b sw: rs+simm (address), never sets overflow
// - Set-less-than ops: result = {31'b0, less}; flags[1] = less.
// - flags[0] overflow: add/addi/sub only; two's-complement rule (operands same sign and
//   result sign differs for add; operand signs differ and result sign differs from rs for
//   sub). Result is the wrapped 32-bit sum/difference regardless.
// - flags[2] zero: beq/bne only, set when rs-rt == 0 (bne still reports zero; branch
//   decision is the caller's).
// - All flag bits not defined for the current instruction are 0.
// - Unsupported opcode/funct: result=0, flags=000.
// - All arithmetic 32-bit modulo 2^32; shift amounts 0..31; shift by 0 passes rt.
// TESTING
//   add 0x00010020, regA=7fffffff, regB=8 -> next edge result=80000007, flags=001.
//   sub 0x00010022, regA=1, regB=2 -> result=ffffffff, flags=000; subu regA=7fffffff,
//     regB=ffffffff -> 80000000, flags=000.
//   beq 0x10010001, regA=regB=1 -> result=0, flags=100; regA=0 -> result=ffffffff, flags=000.
//   slt 0x0001002a, regA=f0000000, regB=0 -> 1, flags=010; sltu 0x0001002b same regs -> 0, 000;
//     sltiu imm=8000, rs=regA=0 -> 1, flags=010.
//   Shifts: sra shamt=8, regB=f0000000 -> fff00000; srav regA=10, regB=f0000000 -> fffff000;
//     sll shamt=10, regB=1 -> 00000400; lw 0x8c01700f, regA=1 -> 00007010, flags=000.
//   Reset: assert rst_n=0 mid-run between edges -> result=0, flags=000 at once; holds until
//     first edge after release; addi rs-field=1, imm=1, regB=3 -> result=4 after that edge.

Source files
------------

// File: rtl/alu.sv
// MIPS32 EX-stage integer ALU: decodes the raw instruction word, selects operands,
// and registers a 32-bit result with {zero, negative, overflow} flags.
module alu (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic [31:0] regA,
   input  logic [31:0] regB,
   output logic [31:0] result,
   output logic [2:0]  flags
);

   localparam logic [5:0] op_rtype = 6'h00;
   localparam logic [5:0] op_beq   = 6'h04;
   localparam logic [5:0] op_bne   = 6'h05;
   localparam logic [5:0] op_addi  = 6'h08;
   localparam logic [5:0] op_addiu = 6'h09;
   localparam logic [5:0] op_slti  = 6'h0a;
   localparam logic [5:0] op_sltiu = 6'h0b;
   localparam logic [5:0] op_andi  = 6'h0c;
   localparam logic [5:0] op_ori   = 6'h0d;
   localparam logic [5:0] op_xori  = 6'h0e;
   localparam logic [5:0] op_lw    = 6'h23;
   localparam logic [5:0] op_sw    = 6'h2b;

   localparam logic [5:0] fn_sll  = 6'h00;
   localparam logic [5:0] fn_srl  = 6'h02;
   localparam logic [5:0] fn_sra  = 6'h03;
   localparam logic [5:0] fn_sllv = 6'h04;
   localparam logic [5:0] fn_srlv = 6'h06;
   localparam logic [5:0] fn_srav = 6'h07;
   localparam logic [5:0] fn_add  = 6'h20;
   localparam logic [5:0] fn_addu = 6'h21;
   localparam logic [5:0] fn_sub  = 6'h22;
   localparam logic [5:0] fn_subu = 6'h23;
   localparam logic [5:0] fn_and  = 6'h24;
   localparam logic [5:0] fn_or   = 6'h25;
   localparam logic [5:0] fn_xor  = 6'h26;
   localparam logic [5:0] fn_nor  = 6'h27;
   localparam logic [5:0] fn_slt  = 6'h2a;
   localparam logic [5:0] fn_sltu = 6'h2b;

   // Signed overflow of a + b = s: same-sign operands, result sign differs.
   function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] s);
      return (a[31] == b[31]) && (s[31] != a[31]);
   endfunction

   // Signed overflow of a - b = d: operand signs differ, result sign differs from a.
   function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] d);
      return (a[31] != b[31]) && (d[31] != a[31]);
   endfunction

   logic [5:0]  opcode_s;
   logic [5:0]  funct_s;
   logic [4:0]  shamt_s;
   logic [31:0] rs_s;
   logic [31:0] rt_s;
   logic [31:0] simm_s;
   logic [31:0] zimm_s;
   logic [31:0] sum_rt_s;
   logic [31:0] diff_rt_s;
   logic [31:0] sum_imm_s;
   logic [31:0] res_s;
   logic [2:0]  flags_s;
   logic [31:0] result_r;
   logic [2:0]  flags_r;

   assign opcode_s  = instruction[31:26];
   assign funct_s   = instruction[5:0];
   assign shamt_s   = instruction[10:6];
   // A zero register field selects regA, any other field value selects regB.
   assign rs_s      = (instruction[25:21] == 5'd0) ? regA : regB;
   assign rt_s      = (instruction[20:16] == 5'd0) ? regA : regB;
   assign simm_s    = {{16{instruction[15]}}, instruction[15:0]};
   assign zimm_s    = {16'h0000, instruction[15:0]};
   assign sum_rt_s  = rs_s + rt_s;
   assign diff_rt_s = rs_s - rt_s;
   assign sum_imm_s = rs_s + simm_s;

   // Combinational decode and evaluation of the current instruction.
   always_comb begin
      res_s   = 32'h0000_0000;
      flags_s = 3'b000;
      case (opcode_s)
         op_rtype: begin
            case (funct_s)
               fn_add:  begin res_s = sum_rt_s;  flags_s = {2'b00, add_ovf(rs_s, rt_s, sum_rt_s)}; end
               fn_addu: res_s = sum_rt_s;
               fn_sub:  begin res_s = diff_rt_s; flags_s = {2'b00, sub_ovf(rs_s, rt_s, diff_rt_s)}; end
               fn_subu: res_s = diff_rt_s;
               fn_and:  res_s = rs_s & rt_s;
               fn_or:   res_s = rs_s | rt_s;
               fn_xor:  res_s = rs_s ^ rt_s;
               fn_nor:  res_s = ~(rs_s | rt_s);
               fn_slt: begin
                  res_s   = {31'd0, ($signed(rs_s) < $signed(rt_s))};
                  flags_s = {1'b0, res_s[0], 1'b0};
               end
               fn_sltu: begin
                  res_s   = {31'd0, (rs_s < rt_s)};
                  flags_s = {1'b0, res_s[0], 1'b0};
               end
               fn_sll:  res_s = rt_s << shamt_s;
               fn_srl:  res_s = rt_s >> shamt_s;
               fn_sra:  res_s = $signed(rt_s) >>> shamt_s;
               fn_sllv: res_s = rt_s << rs_s[4:0];
               fn_srlv: res_s = rt_s >> rs_s[4:0];
               fn_srav: res_s = $signed(rt_s) >>> rs_s[4:0];
               default: begin
                  res_s   = 32'h0000_0000;
                  flags_s = 3'b000;
               end
            endcase
         end
         op_addi:  begin res_s = sum_imm_s; flags_s = {2'b00, add_ovf(rs_s, simm_s, sum_imm_s)}; end
         op_addiu: res_s = sum_imm_s;
         op_slti: begin
            res_s   = {31'd0, ($signed(rs_s) < $signed(simm_s))};
            flags_s = {1'b0, res_s[0], 1'b0};
         end
         op_sltiu: begin
            res_s   = {31'd0, (rs_s < simm_s)};
            flags_s = {1'b0, res_s[0], 1'b0};
         end
         op_andi:  res_s = rs_s & zimm_s;
         op_ori:   res_s = rs_s | zimm_s;
         op_xori:  res_s = rs_s ^ zimm_s;
         // Branches only report equality; taking the branch is decided downstream.
         op_beq, op_bne: begin
            res_s   = diff_rt_s;
            flags_s = {(diff_rt_s == 32'h0000_0000), 2'b00};
         end
         op_lw, op_sw: res_s = sum_imm_s;
         default: begin
            res_s   = 32'h0000_0000;
            flags_s = 3'b000;
         end
      endcase
   end

   // Output register; clears asynchronously on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_r <= 32'h0000_0000;
         flags_r  <= 3'b000;
      end else begin
         result_r <= res_s;
         flags_r  <= flags_s;
      end
   end

   assign result = result_r;
   assign flags  = flags_r;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: directed vectors with known answers plus random
// instructions checked against an arithmetic reference model.
module tb_alu;

   typedef struct packed {
      logic [31:0] res;
      logic [2:0]  flg;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] instruction;
   logic [31:0] regA;
   logic [31:0] regB;
   logic [31:0] result;
   logic [2:0]  flags;

   int checks = 0;
   int errors = 0;
   exp_t exp_q[$];
   int   tag_q[$];

   alu dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction),
      .regA(regA), .regB(regB), .result(result), .flags(flags)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int tag, input exp_t act, input exp_t req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s #%0d: got result=%h flags=%b, expected result=%h flags=%b",
                  name, tag, act.res, act.flg, req.res, req.flg);
      end
   endtask

   // True when a 64-bit value is representable as a signed 32-bit number.
   function automatic bit fits32(input longint v);
      logic [63:0] t;
      t = v;
      return v == longint'($signed(t[31:0]));
   endfunction

   function automatic exp_t ref_model(input logic [31:0] ins, input logic [31:0] a,
                                      input logic [31:0] b);
      logic [31:0] rs, rt;
      longint srs, srt, urs, urt, simm, zimm, usimm, r;
      int sh, shv;
      logic ovf, neg, zero;
      logic [63:0] rv;
      exp_t e;
      rs = (ins[25:21] == 5'd0) ? a : b;
      rt = (ins[20:16] == 5'd0) ? a : b;
      srs = longint'($signed(rs));
      srt = longint'($signed(rt));
      urs = longint'(rs);
      urt = longint'(rt);
      simm = longint'($signed(ins[15:0]));
      zimm = longint'(ins[15:0]);
      usimm = simm & 64'h0000_0000_ffff_ffff;
      sh = int'(ins[10:6]);
      shv = int'(rs[4:0]);
      r = 0; ovf = 1'b0; neg = 1'b0; zero = 1'b0;
      if (ins[31:26] == 6'h00) begin
         case (ins[5:0])
            6'h20: begin r = srs + srt; ovf = !fits32(r); end
            6'h21: r = srs + srt;
            6'h22: begin r = srs - srt; ovf = !fits32(r); end
            6'h23: r = srs - srt;
            6'h24: r = urs & urt;
            6'h25: r = urs | urt;
            6'h26: r = urs ^ urt;
            6'h27: r = ~(urs | urt);
            6'h2a: begin neg = (srs < srt); r = neg ? 1 : 0; end
            6'h2b: begin neg = (urs < urt); r = neg ? 1 : 0; end
            6'h00: r = urt << sh;
            6'h02: r = urt >> sh;
            6'h03: r = srt >>> sh;
            6'h04: r = urt << shv;
            6'h06: r = urt >> shv;
            6'h07: r = srt >>> shv;
            default: r = 0;
         endcase
      end else begin
         case (ins[31:26])
            6'h08: begin r = srs + simm; ovf = !fits32(r); end
            6'h09: r = srs + simm;
            6'h0a: begin neg = (srs < simm); r = neg ? 1 : 0; end
            6'h0b: begin neg = (urs < usimm); r = neg ? 1 : 0; end
            6'h0c: r = urs & zimm;
            6'h0d: r = urs | zimm;
            6'h0e: r = urs ^ zimm;
            6'h04, 6'h05: begin r = srs - srt; rv = r; zero = (rv[31:0] == 32'd0); end
            6'h23, 6'h2b: r = srs + simm;
            default: r = 0;
         endcase
      end
      rv = r;
      e.res = rv[31:0];
      e.flg = {zero, neg, ovf};
      return e;
   endfunction

   task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input exp_t e, input int tag);
      @(negedge clk);
      instruction = ins;
      regA = a;
      regB = b;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   function automatic logic [31:0] pick_val();
      logic [31:0] corners [6];
      corners[0] = 32'h0000_0000; corners[1] = 32'hffff_ffff; corners[2] = 32'h7fff_ffff;
      corners[3] = 32'h8000_0000; corners[4] = 32'h0000_0001; corners[5] = 32'h0000_001f;
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   // Monitor: one registered result per edge for each queued expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            check("alu_out", tag_q.pop_front(), {result, flags}, exp_q.pop_front());
         end
      end
   end

   typedef struct {
      logic [31:0] ins, a, b, res;
      logic [2:0]  flg;
   } vec_t;

   vec_t vecs[$];
   logic [5:0] rfn [16];
   logic [5:0] iop [11];

   initial begin
      logic [31:0] ins, a, b;
      int pick;
      vecs = '{
         '{32'h0001_0020, 32'h7fff_ffff, 32'h0000_0008, 32'h8000_0007, 3'b001},
         '{32'h0001_0022, 32'h0000_0001, 32'h0000_0002, 32'hffff_ffff, 3'b000},
         '{32'h0001_0023, 32'h7fff_ffff, 32'hffff_ffff, 32'h8000_0000, 3'b000},
         '{32'h0001_0022, 32'h8000_0000, 32'h0000_0001, 32'h7fff_ffff, 3'b001},
         '{32'h1001_0001, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 3'b100},
         '{32'h1001_0001, 32'h0000_0000, 32'h0000_0001, 32'hffff_ffff, 3'b000},
         '{32'h1401_0000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 3'b100},
         '{32'h0001_002a, 32'hf000_0000, 32'h0000_0000, 32'h0000_0001, 3'b010},
         '{32'h0001_002b, 32'hf000_0000, 32'h0000_0000, 32'h0000_0000, 3'b000},
         '{32'h2c00_8000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 3'b010},
         '{32'h0001_0203, 32'h0000_0000, 32'hf000_0000, 32'hfff0_0000, 3'b000},
         '{32'h0001_0007, 32'h0000_0010, 32'hf000_0000, 32'hffff_f000, 3'b000},
         '{32'h0001_0280, 32'h0000_0000, 32'h0000_0001, 32'h0000_0400, 3'b000},
         '{32'h0001_0003, 32'h0000_0000, 32'h8000_0000, 32'h8000_0000, 3'b000},
         '{32'h8c01_700f, 32'h0000_0001, 32'h0000_0000, 32'h0000_7010, 3'b000},
         '{32'hac01_ffff, 32'h8000_0000, 32'h0000_0000, 32'h7fff_ffff, 3'b000},
         '{32'h2000_0001, 32'h7fff_ffff, 32'h0000_0000, 32'h8000_0000, 3'b001},
         '{32'h2400_0001, 32'h7fff_ffff, 32'h0000_0000, 32'h8000_0000, 3'b000},
         '{32'hfc00_0000, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 3'b000},
         '{32'h0001_0001, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 3'b000}
      };
      rfn = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
              6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
      iop = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h04, 6'h05, 6'h23, 6'h2b};

      instruction = 32'h0000_0000;
      regA = 32'h0000_0000;
      regB = 32'h0000_0000;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1 check("reset_async", 0, {result, flags}, {32'h0000_0000, 3'b000});
      repeat (2) @(negedge clk);
      check("reset_hold", 0, {result, flags}, {32'h0000_0000, 3'b000});
      rst_n = 1'b1;

      foreach (vecs[i]) issue(vecs[i].ins, vecs[i].a, vecs[i].b, {vecs[i].res, vecs[i].flg}, i);

      for (int n = 0; n < 400; n++) begin
         ins = $urandom;
         pick = $urandom_range(0, 9);
         if (pick < 5) begin
            ins[31:26] = 6'h00;
            ins[5:0] = rfn[$urandom_range(0, 15)];
         end else if (pick < 9) begin
            ins[31:26] = iop[$urandom_range(0, 10)];
         end else begin
            ins[31:26] = ins[31:26];
         end
         if ($urandom_range(0, 1) == 1) ins[25:21] = 5'd0;
         if ($urandom_range(0, 1) == 1) ins[20:16] = 5'd0;
         a = pick_val();
         b = pick_val();
         issue(ins, a, b, ref_model(ins, a, b), 1000 + n);
      end

      // Reset between edges while the output holds a nonzero value.
      issue(32'h0001_0021, 32'h0000_0001, 32'h0000_0002, {32'h0000_0003, 3'b000}, 2000);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 check("reset_midrun", 1, {result, flags}, {32'h0000_0000, 3'b000});
      @(posedge clk);
      #1 check("reset_midrun_edge", 2, {result, flags}, {32'h0000_0000, 3'b000});
      @(negedge clk);
      rst_n = 1'b1;
      instruction = 32'h2020_0001;
      regA = 32'h0000_0000;
      regB = 32'h0000_0003;
      #1 check("reset_release_hold", 3, {result, flags}, {32'h0000_0000, 3'b000});
      exp_q.push_back({32'h0000_0004, 3'b000});
      tag_q.push_back(2001);

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d expected results still pending, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
